// File: rtl/line_drawer_if.sv
// Request/pixel-stream bundle between the lab top-level FSM, the line drawer
// and the VGA adapter. master = requester/monitor side, slave = line_drawer.
interface line_drawer_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [2:0] colour;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output start, x0, y0, x1, y1, colour,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x0, y0, x1, y1, colour,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/line_drawer.sv
// Bresenham line rasteriser feeding the VGA adapter, one pixel per clock.
// Define LINE_DRAWER_CLIP_EN to suppress plot strobes for off-screen points.
module line_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          clk,
  input  logic          rst_n,
  line_drawer_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_DRAW, ST_DONE} state_t;

  state_t            state_r;
  logic [7:0]        x0_r;
  logic [6:0]        y0_r;
  logic [7:0]        x1_r;
  logic [6:0]        y1_r;
  logic [2:0]        colour_r;
  logic [7:0]        dx_r;
  logic signed [8:0] dy_r;
  logic              sx_neg_r;
  logic              sy_neg_r;
  logic signed [9:0] err_r;
  logic [7:0]        cur_x_r;
  logic [6:0]        cur_y_r;
  logic              done_r;
  logic [7:0]        vga_x_r;
  logic [6:0]        vga_y_r;
  logic [2:0]        vga_colour_r;
  logic              vga_plot_r;

  logic [7:0]         init_dx_s;
  logic [6:0]         init_ady_s;
  logic signed [8:0]  init_dy_s;
  logic signed [9:0]  init_err_s;
  logic signed [10:0] e2_s;
  logic signed [10:0] dx_ext_s;
  logic signed [10:0] dy_ext_s;
  logic               step_x_s;
  logic               step_y_s;
  logic signed [9:0]  err_next_s;
  logic               at_end_s;
  logic               plot_en_s;

  // Setup arithmetic from the latched endpoints and the per-pixel Bresenham step.
  always_comb begin
    init_dx_s  = 8'd0;
    init_ady_s = 7'd0;
    if (x1_r >= x0_r) begin
      init_dx_s = x1_r - x0_r;
    end else begin
      init_dx_s = x0_r - x1_r;
    end
    if (y1_r >= y0_r) begin
      init_ady_s = y1_r - y0_r;
    end else begin
      init_ady_s = y0_r - y1_r;
    end
    init_dy_s  = 9'sd0 - $signed({2'b00, init_ady_s});
    init_err_s = $signed({2'b00, init_dx_s}) + $signed({init_dy_s[8], init_dy_s});

    e2_s       = $signed({err_r, 1'b0});
    dx_ext_s   = $signed({3'b000, dx_r});
    dy_ext_s   = $signed({{2{dy_r[8]}}, dy_r});
    step_x_s   = (e2_s >= dy_ext_s);
    step_y_s   = (e2_s <= dx_ext_s);
    // err stays within roughly [1.5*dy, 1.5*dx], so 10 bits never overflow.
    err_next_s = err_r;
    if (step_x_s) begin
      err_next_s = err_next_s + $signed({dy_r[8], dy_r});
    end else begin
      err_next_s = err_next_s;
    end
    if (step_y_s) begin
      err_next_s = err_next_s + $signed({2'b00, dx_r});
    end else begin
      err_next_s = err_next_s;
    end

    at_end_s = (cur_x_r == x1_r) && (cur_y_r == y1_r);
`ifdef LINE_DRAWER_CLIP_EN
    plot_en_s = (cur_x_r < 8'(SCREEN_W)) && (cur_y_r < 7'(SCREEN_H));
`else
    plot_en_s = 1'b1;
`endif
  end

  // Control FSM with registered adapter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      x0_r         <= 8'd0;
      y0_r         <= 7'd0;
      x1_r         <= 8'd0;
      y1_r         <= 7'd0;
      colour_r     <= 3'd0;
      dx_r         <= 8'd0;
      dy_r         <= 9'sd0;
      sx_neg_r     <= 1'b0;
      sy_neg_r     <= 1'b0;
      err_r        <= 10'sd0;
      cur_x_r      <= 8'd0;
      cur_y_r      <= 7'd0;
      done_r       <= 1'b0;
      vga_x_r      <= 8'd0;
      vga_y_r      <= 7'd0;
      vga_colour_r <= 3'd0;
      vga_plot_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r     <= 1'b0;
          vga_plot_r <= 1'b0;
          if (bus.start) begin
            x0_r     <= bus.x0;
            y0_r     <= bus.y0;
            x1_r     <= bus.x1;
            y1_r     <= bus.y1;
            colour_r <= bus.colour;
            state_r  <= ST_INIT;
          end
        end
        ST_INIT: begin
          vga_plot_r <= 1'b0;
          dx_r       <= init_dx_s;
          dy_r       <= init_dy_s;
          sx_neg_r   <= (x0_r >= x1_r);
          sy_neg_r   <= (y0_r >= y1_r);
          err_r      <= init_err_s;
          cur_x_r    <= x0_r;
          cur_y_r    <= y0_r;
          state_r    <= ST_DRAW;
        end
        ST_DRAW: begin
          vga_x_r      <= cur_x_r;
          vga_y_r      <= cur_y_r;
          vga_colour_r <= colour_r;
          vga_plot_r   <= plot_en_s;
          if (at_end_s) begin
            state_r <= ST_DONE;
          end else begin
            err_r <= err_next_s;
            if (step_x_s) begin
              cur_x_r <= sx_neg_r ? (cur_x_r - 8'd1) : (cur_x_r + 8'd1);
            end
            if (step_y_s) begin
              cur_y_r <= sy_neg_r ? (cur_y_r - 7'd1) : (cur_y_r + 7'd1);
            end
          end
        end
        ST_DONE: begin
          vga_plot_r <= 1'b0;
          // A held start keeps us here, so it can never re-trigger a draw.
          if (bus.start) begin
            done_r <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          done_r     <= 1'b0;
          vga_plot_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done       = done_r;
  assign bus.vga_x      = vga_x_r;
  assign bus.vga_y      = vga_y_r;
  assign bus.vga_colour = vga_colour_r;
  assign bus.vga_plot   = vga_plot_r;

endmodule

// File: tb/tb_line_drawer.sv
// Randomised and directed bench for line_drawer against an integer line model.
module tb_line_drawer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  line_drawer_if bus ();

  line_drawer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef LINE_DRAWER_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Draws one line and checks pixels, timing and handshake; hold_cycles keeps start high after done.
  task automatic run_line(input string tag, input int ax0, input int ay0, input int ax1,
                          input int ay1, input int col, input int hold_cycles);
    int pts_x[$];
    int pts_y[$];
    int exp_p[$];
    int got_p[$];
    int first_idx;
    int dx, dy, sx, sy, err, e2, x, y;
    int c, first_c, done_c, bad_col, overlap, late_plots, done_low;
    // Reference point list from integer Bresenham.
    dx = iabs(ax1 - ax0);
    dy = -iabs(ay1 - ay0);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    forever begin
      pts_x.push_back(x);
      pts_y.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    first_idx = -1;
    foreach (pts_x[i]) begin
      if (on_screen(pts_x[i], pts_y[i])) begin
        exp_p.push_back(pts_x[i] * 256 + pts_y[i]);
        if (first_idx < 0) first_idx = i;
      end
    end
    check_val({tag, "_draw_len"}, pts_x.size(), ((dx > -dy) ? dx : -dy) + 1);

    bus.x0 = 8'(ax0); bus.y0 = 7'(ay0); bus.x1 = 8'(ax1); bus.y1 = 7'(ay1);
    bus.colour = 3'(col);
    bus.start = 1'b1;
    @(posedge clk); #1;
    // Inputs after the latch must be ignored.
    bus.x0 = 8'($urandom); bus.y0 = 7'($urandom); bus.x1 = 8'($urandom);
    bus.y1 = 7'($urandom); bus.colour = 3'($urandom);
    c = 0; first_c = -1; done_c = -1; bad_col = 0; overlap = 0;
    while (c < 600 && done_c < 0) begin
      @(posedge clk); #1;
      c++;
      if (bus.vga_plot) begin
        if (first_c < 0) first_c = c;
        got_p.push_back(int'(bus.vga_x) * 256 + int'(bus.vga_y));
        if (int'(bus.vga_colour) != col) bad_col++;
      end
      if (bus.done) begin
        done_c = c;
        if (bus.vga_plot) overlap++;
      end
    end
    check_val({tag, "_done_seen"}, int'(done_c >= 0), 1);
    check_val({tag, "_done_cycle"}, done_c, 2 + pts_x.size());
    check_val({tag, "_plot_count"}, got_p.size(), exp_p.size());
    if (first_idx >= 0) check_val({tag, "_first_plot_cycle"}, first_c, 2 + first_idx);
    check_val({tag, "_colour"}, bad_col, 0);
    check_val({tag, "_plot_with_done"}, overlap, 0);
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) begin
      check_val($sformatf("%s_pix%0d", tag, i), got_p[i], exp_p[i]);
    end

    late_plots = 0; done_low = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      if (bus.vga_plot) late_plots++;
      if (!bus.done) done_low++;
    end
    if (hold_cycles > 0) begin
      check_val({tag, "_hold_plots"}, late_plots, 0);
      check_val({tag, "_hold_done_low"}, done_low, 0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_done_drop"}, int'(bus.done), 0);
    check_val({tag, "_idle_plot"}, int'(bus.vga_plot), 0);
  endtask

  initial begin
    int nplot, c;
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.x1 = 8'd0; bus.y1 = 7'd0; bus.colour = 3'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_plot", int'(bus.vga_plot), 0);
    check_val("rst_vga_x", int'(bus.vga_x), 0);
    check_val("rst_vga_y", int'(bus.vga_y), 0);
    check_val("rst_colour", int'(bus.vga_colour), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_line("horiz", 0, 5, 159, 5, 4, 0);
    run_line("zero", 42, 17, 42, 17, 5, 0);
    run_line("revdiag", 10, 10, 0, 0, 2, 0);
    run_line("steep", 5, 0, 7, 10, 7, 0);
    run_line("vert_up", 80, 119, 80, 0, 1, 0);
    run_line("clip_hold", 150, 60, 170, 60, 6, 100);

    for (int k = 0; k < 30; k++) begin
      run_line($sformatf("rnd%0d", k), int'($urandom_range(159, 0)), int'($urandom_range(119, 0)),
               int'($urandom_range(159, 0)), int'($urandom_range(119, 0)),
               int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
    end

    // Reset in the middle of a long line.
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.x1 = 8'd159; bus.y1 = 7'd119; bus.colour = 3'd3;
    bus.start = 1'b1;
    nplot = 0; c = 0;
    while (nplot < 20 && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (bus.vga_plot) nplot++;
    end
    check_val("midrst_reached20", nplot, 20);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_plot", int'(bus.vga_plot), 0);
    check_val("midrst_done", int'(bus.done), 0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    nplot = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.vga_plot || bus.done) nplot++;
    end
    check_val("midrst_quiet", nplot, 0);
    run_line("after_rst", 3, 100, 20, 90, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
